// File: rtl/frame_stream_tx_if.sv
// Stream bundle for frame_stream_tx: valid/ready word input plus vsync/hsync/valid raster output.
// The slave modport is the transmitter side; master is its producer/consumer.
interface frame_stream_tx_if #(
    parameter int unsigned WIDTH_D = 27
);
    logic               i_valid;
    logic [WIDTH_D-1:0] i_tdata;
    logic               o_ready;
    logic               o_vsync;
    logic               o_hsync;
    logic               o_valid;
    logic [WIDTH_D-1:0] o_tdata;

    modport master (
        output i_valid, i_tdata,
        input  o_ready, o_vsync, o_hsync, o_valid, o_tdata
    );

    modport slave (
        input  i_valid, i_tdata,
        output o_ready, o_vsync, o_hsync, o_valid, o_tdata
    );
endinterface

// File: rtl/frame_stream_tx.sv
// Frame-stream transmitter: FIFO-buffered words re-emitted as vsync, then SIZE rows of
// hsync plus ROW_BEATS contiguous valid beats. The FIFO accepts words in every state.
module frame_stream_tx #(
    parameter int unsigned WIDTH_D = 27,
    parameter int unsigned SIZE    = 28,
    parameter int unsigned CHANNEL = 8,
    parameter int unsigned GAP     = 4,
    parameter int unsigned VS_LEN  = 4,
    parameter int unsigned DEPTH   = 256
) (
    input  logic             i_sclk,
    input  logic             i_rst,
    input  logic             i_start,
    frame_stream_tx_if.slave bus,
    output logic             o_busy,
    output logic             o_frame_done,
    output logic             o_ovf
);
    localparam int unsigned ROW_BEATS = SIZE * CHANNEL;
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned RW   = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int unsigned BW   = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;
    localparam int unsigned CMAX = (VS_LEN > GAP) ? VS_LEN : GAP;
    localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [2:0] {StIdle, StVs, StWait, StHs, StData, StGap} state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [RW-1:0]      r_row;
    logic [BW-1:0]      r_beat;
    logic               r_vsync;
    logic               r_hsync;
    logic               r_valid;
    logic               r_busy;
    logic               r_done;
    logic               r_ovf;
    logic [WIDTH_D-1:0] r_tdata;

    logic [WIDTH_D-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [AW:0]        r_count;

    logic w_full;
    logic w_wr;
    logic w_rd;
    logic w_last_beat;
    logic w_row_end;

    assign w_full      = (r_count == (AW+1)'(DEPTH));
    assign w_wr        = bus.i_valid && !w_full;
    assign w_last_beat = (r_beat == BW'(ROW_BEATS - 1));
    // Pops lead o_valid by one edge: the HS edge loads beat 0, DATA edges load the rest.
    assign w_rd        = (r_state == StHs) || ((r_state == StData) && !w_last_beat);
    // The zero-cycle END decision happens on the edge leaving DATA (no gap) or GAP.
    assign w_row_end   = ((r_state == StData) && w_last_beat && (GAP == 0)) ||
                         ((r_state == StGap) && (r_cnt == CW'(GAP - 1)));

    always_ff @(posedge i_sclk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= bus.i_tdata;
        end
    end

    always_ff @(posedge i_sclk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_wr && !w_rd) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr && w_rd) begin
                r_count <= r_count - 1'b1;
            end
            if (bus.i_valid && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_sclk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_row   <= '0;
            r_beat  <= '0;
            r_vsync <= 1'b0;
            r_hsync <= 1'b0;
            r_valid <= 1'b0;
            r_tdata <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_hsync <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= w_rd;
            r_tdata <= w_rd ? r_mem[r_rptr] : '0;
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_state <= StVs;
                        r_vsync <= 1'b1;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_row   <= '0;
                        r_beat  <= '0;
                    end
                end
                StVs: begin
                    if (r_cnt == CW'(VS_LEN - 1)) begin
                        r_state <= StWait;
                        r_vsync <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StWait: begin
                    if (r_count >= (AW+1)'(ROW_BEATS)) begin
                        r_state <= StHs;
                        r_hsync <= 1'b1;
                    end
                end
                StHs: begin
                    r_state <= StData;
                    r_beat  <= '0;
                end
                StData: begin
                    if (!w_last_beat) begin
                        r_beat <= r_beat + 1'b1;
                    end else if (GAP != 0) begin
                        r_state <= StGap;
                        r_cnt   <= '0;
                    end
                end
                StGap: begin
                    if (!w_row_end) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
            if (w_row_end) begin
                r_cnt <= '0;
                if (r_row == RW'(SIZE - 1)) begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end else begin
                    r_row   <= r_row + 1'b1;
                    r_state <= StWait;
                end
            end
        end
    end

    assign bus.o_ready  = !w_full;
    assign bus.o_vsync  = r_vsync;
    assign bus.o_hsync  = r_hsync;
    assign bus.o_valid  = r_valid;
    assign bus.o_tdata  = r_tdata;
    assign o_busy       = r_busy;
    assign o_frame_done = r_done;
    assign o_ovf        = r_ovf;
endmodule

// File: tb/tb_frame_stream_tx.sv
// Directed bench for frame_stream_tx with SIZE=3, CHANNEL=2, GAP=2, VS_LEN=2, DEPTH=8.
// Inputs change and outputs are sampled on the falling edge.
module tb_frame_stream_tx;
    localparam int unsigned WD      = 27;
    localparam int unsigned SIZE    = 3;
    localparam int unsigned CHANNEL = 2;
    localparam int unsigned GAP     = 2;
    localparam int unsigned VS_LEN  = 2;
    localparam int unsigned DEPTH   = 8;
    localparam int          RB      = 6;

    logic clk;
    logic rst;
    logic start;
    logic busy;
    logic frame_done;
    logic ovf;

    frame_stream_tx_if #(.WIDTH_D(WD)) bus ();

    frame_stream_tx #(
        .WIDTH_D(WD),
        .SIZE   (SIZE),
        .CHANNEL(CHANNEL),
        .GAP    (GAP),
        .VS_LEN (VS_LEN),
        .DEPTH  (DEPTH)
    ) dut (
        .i_sclk      (clk),
        .i_rst       (rst),
        .i_start     (start),
        .bus         (bus),
        .o_busy      (busy),
        .o_frame_done(frame_done),
        .o_ovf       (ovf)
    );

    // {vsync, hsync, valid, busy, frame_done, ovf, ready}
    logic [6:0] flags;
    assign flags = {bus.o_vsync, bus.o_hsync, bus.o_valid, busy, frame_done, ovf, bus.o_ready};

    int            checks;
    int            failures;
    logic [WD-1:0] cap_q[$];
    int            hs_cnt;
    int            vs_rise;
    int            done_cnt;
    int            order_err;
    int            run;
    logic          prev_valid;
    logic          prev_hsync;
    logic          prev_vsync;
    logic          feed_en;
    int            feed_next;
    int            feed_left;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next falling edge, record outputs, then let the feeder drive.
    task automatic step();
        @(negedge clk);
        if (bus.o_valid) cap_q.push_back(bus.o_tdata);
        if (bus.o_hsync) hs_cnt++;
        if (frame_done) done_cnt++;
        if (bus.o_vsync && !prev_vsync) vs_rise++;
        if (bus.o_valid && !prev_valid && !prev_hsync) order_err++;
        if (bus.o_valid) begin
            run++;
        end else if (prev_valid) begin
            if (run != RB) order_err++;
            run = 0;
        end
        prev_valid = bus.o_valid;
        prev_hsync = bus.o_hsync;
        prev_vsync = bus.o_vsync;
        if (feed_en) begin
            if (feed_left > 0 && bus.o_ready) begin
                bus.i_valid = 1'b1;
                bus.i_tdata = WD'(feed_next);
                feed_next++;
                feed_left--;
            end else begin
                bus.i_valid = 1'b0;
                bus.i_tdata = '0;
            end
        end
    endtask

    task automatic clear_mon();
        cap_q.delete();
        hs_cnt     = 0;
        vs_rise    = 0;
        done_cnt   = 0;
        order_err  = 0;
        run        = 0;
        prev_valid = 1'b0;
        prev_hsync = 1'b0;
        prev_vsync = 1'b0;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        feed_en     = 1'b0;
        start       = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_tdata = '0;
        step();
        step();
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic test_reset();
        do_reset();
        step();
        checks++;
        if (flags !== 7'b0000001) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=%b", flags, 7'b0000001);
        end
        checks++;
        if (bus.o_tdata !== '0) begin
            failures++;
            $display("FAIL reset_tdata got=%0d exp=0", bus.o_tdata);
        end
    endtask

    task automatic test_single_row();
        logic [6:0]    exp_f;
        logic [WD-1:0] exp_d;
        do_reset();
        for (int k = 1; k <= RB; k++) begin
            step();
            bus.i_valid = 1'b1;
            bus.i_tdata = WD'(k);
        end
        step();
        bus.i_valid = 1'b0;
        start       = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            step();
            if (c == 0) start = 1'b0;
            exp_f = {(c < 2), (c == 3), (c >= 4 && c <= 9), 1'b1, 1'b0, 1'b0, 1'b1};
            exp_d = (c >= 4 && c <= 9) ? WD'(c - 3) : '0;
            checks++;
            if (flags !== exp_f) begin
                failures++;
                $display("FAIL row1_flags cyc=%0d got=%b exp=%b", c, flags, exp_f);
            end
            checks++;
            if (bus.o_tdata !== exp_d) begin
                failures++;
                $display("FAIL row1_tdata cyc=%0d got=%0d exp=%0d", c, bus.o_tdata, exp_d);
            end
        end
    endtask

    task automatic test_full_frame();
        logic          seen;
        logic [WD-1:0] got;
        do_reset();
        step();
        start     = 1'b1;
        feed_next = 1;
        feed_left = 18;
        feed_en   = 1'b1;
        step();
        start = 1'b0;
        seen  = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            step();
            if (frame_done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL frame_done_timeout got=0 exp=1");
        end
        step();
        checks++;
        if (flags !== 7'b0000001) begin
            failures++;
            $display("FAIL frame_after_done got=%b exp=%b", flags, 7'b0000001);
        end
        repeat (4) step();
        for (int i = 0; i < 18; i++) begin
            got = (i < cap_q.size()) ? cap_q[i] : 'x;
            checks++;
            if (got !== WD'(i + 1)) begin
                failures++;
                $display("FAIL frame_seq idx=%0d got=%0d exp=%0d", i, got, i + 1);
            end
        end
        checks++;
        if (cap_q.size() != 18 || hs_cnt != 3 || vs_rise != 1 || done_cnt != 1 ||
            order_err != 0) begin
            failures++;
            $display("FAIL frame_counts got beats=%0d hs=%0d vs=%0d done=%0d err=%0d exp 18/3/1/1/0",
                     cap_q.size(), hs_cnt, vs_rise, done_cnt, order_err);
        end
        feed_en = 1'b0;
    endtask

    task automatic test_overflow();
        logic          seen;
        logic [WD-1:0] got;
        logic [WD-1:0] exp_d;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 8) begin
                checks++;
                if (bus.o_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL ovf_ready_at7 got=%b exp=1", bus.o_ready);
                end
            end
            bus.i_valid = 1'b1;
            bus.i_tdata = WD'(k);
        end
        step();
        checks++;
        if ({bus.o_ready, ovf} !== 2'b00) begin
            failures++;
            $display("FAIL ovf_full got ready/ovf=%b exp=00", {bus.o_ready, ovf});
        end
        bus.i_tdata = WD'(99);
        step();
        bus.i_valid = 1'b0;
        checks++;
        if ({bus.o_ready, ovf} !== 2'b01) begin
            failures++;
            $display("FAIL ovf_set got ready/ovf=%b exp=01", {bus.o_ready, ovf});
        end
        repeat (3) step();
        start     = 1'b1;
        feed_next = 100;
        feed_left = 10;
        feed_en   = 1'b1;
        step();
        start = 1'b0;
        seen  = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            step();
            if (frame_done) seen = 1'b1;
        end
        checks++;
        if (!seen || ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky got done=%b ovf=%b exp 1/1", seen, ovf);
        end
        for (int i = 0; i < 18; i++) begin
            got   = (i < cap_q.size()) ? cap_q[i] : 'x;
            exp_d = (i < 8) ? WD'(i + 1) : WD'(100 + i - 8);
            checks++;
            if (got !== exp_d) begin
                failures++;
                $display("FAIL ovf_seq idx=%0d got=%0d exp=%0d", i, got, exp_d);
            end
        end
        feed_en = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        logic          found;
        logic          seen;
        logic [WD-1:0] got;
        do_reset();
        step();
        start     = 1'b1;
        feed_next = 1;
        feed_left = 18;
        feed_en   = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            step();
            if (hs_cnt == 2 && bus.o_valid && bus.o_tdata == WD'(10)) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL midrst_reach got=0 exp=1");
        end
        rst         = 1'b1;
        feed_en     = 1'b0;
        bus.i_valid = 1'b0;
        step();
        checks++;
        if (flags !== 7'b0000001 || bus.o_tdata !== '0) begin
            failures++;
            $display("FAIL midrst_outputs got=%b/%0d exp=%b/0", flags, bus.o_tdata, 7'b0000001);
        end
        rst = 1'b0;
        step();
        clear_mon();
        repeat (4) step();
        checks++;
        if (hs_cnt != 0 || cap_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_quiet got hs=%0d beats=%0d busy=%b exp 0/0/0",
                     hs_cnt, cap_q.size(), busy);
        end
        start     = 1'b1;
        feed_next = 201;
        feed_left = 18;
        feed_en   = 1'b1;
        step();
        start = 1'b0;
        seen  = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            step();
            if (frame_done) seen = 1'b1;
        end
        checks++;
        if (!seen || hs_cnt != 3 || order_err != 0) begin
            failures++;
            $display("FAIL midrst_restart got done=%b hs=%0d err=%0d exp 1/3/0",
                     seen, hs_cnt, order_err);
        end
        for (int i = 0; i < 18; i++) begin
            got = (i < cap_q.size()) ? cap_q[i] : 'x;
            checks++;
            if (got !== WD'(201 + i)) begin
                failures++;
                $display("FAIL midrst_seq idx=%0d got=%0d exp=%0d", i, got, 201 + i);
            end
        end
        feed_en = 1'b0;
    endtask

    task automatic test_start_ignored();
        logic found;
        logic seen;
        do_reset();
        step();
        start     = 1'b1;
        feed_next = 1;
        feed_left = 18;
        feed_en   = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            step();
            if (cap_q.size() == RB && !bus.o_valid) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL gapstart_reach got=0 exp=1");
        end
        start = 1'b1;
        step();
        start = 1'b0;
        seen  = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            step();
            if (frame_done) seen = 1'b1;
        end
        step();
        checks++;
        if (!seen || busy !== 1'b0 || hs_cnt != 3 || vs_rise != 1 || cap_q.size() != 18) begin
            failures++;
            $display("FAIL gapstart_frame got done=%b busy=%b hs=%0d vs=%0d beats=%0d exp 1/0/3/1/18",
                     seen, busy, hs_cnt, vs_rise, cap_q.size());
        end
        repeat (4) step();
        checks++;
        if (vs_rise != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL gapstart_queued got vs=%0d busy=%b exp 1/0", vs_rise, busy);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({bus.o_vsync, busy} !== 2'b11) begin
            failures++;
            $display("FAIL gapstart_restart got vsync/busy=%b exp=11", {bus.o_vsync, busy});
        end
        feed_en = 1'b0;
    endtask

    task automatic test_hsync_holdoff();
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            step();
            bus.i_valid = 1'b1;
            bus.i_tdata = WD'(k);
        end
        step();
        bus.i_valid = 1'b0;
        start       = 1'b1;
        step();
        start = 1'b0;
        repeat (20) step();
        checks++;
        if (hs_cnt != 0 || cap_q.size() != 0 || flags !== 7'b0001001) begin
            failures++;
            $display("FAIL holdoff_wait got hs=%0d beats=%0d flags=%b exp 0/0/%b",
                     hs_cnt, cap_q.size(), flags, 7'b0001001);
        end
        bus.i_valid = 1'b1;
        bus.i_tdata = WD'(6);
        step();
        bus.i_valid = 1'b0;
        checks++;
        if ({bus.o_hsync, bus.o_valid} !== 2'b00) begin
            failures++;
            $display("FAIL holdoff_count6 got hsync/valid=%b exp=00", {bus.o_hsync, bus.o_valid});
        end
        step();
        checks++;
        if ({bus.o_hsync, bus.o_valid} !== 2'b10) begin
            failures++;
            $display("FAIL holdoff_hsync got hsync/valid=%b exp=10", {bus.o_hsync, bus.o_valid});
        end
        step();
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_tdata !== WD'(1)) begin
            failures++;
            $display("FAIL holdoff_first got valid=%b tdata=%0d exp 1/1", bus.o_valid, bus.o_tdata);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        start       = 1'b0;
        feed_en     = 1'b0;
        feed_next   = 0;
        feed_left   = 0;
        bus.i_valid = 1'b0;
        bus.i_tdata = '0;
        clear_mon();
        test_reset();
        test_single_row();
        test_full_frame();
        test_overflow();
        test_reset_mid_frame();
        test_start_ignored();
        test_hsync_holdoff();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
